// File: rtl/coeff_decompress.sv
// Unpacks MSB-aligned 64-bit coefficient words into 256 Kyber coefficients.
// Applies Decompress_d for l<12 and reduces mod Q for l=12.
//
// state   | meaning
// S_IDLE  | waiting for the first word of a polynomial
// S_RUN   | unpacking words, streaming coefficients
// S_FLUSH | 256 coefficients sent; draining FIFO until i_done
// S_DONE  | one-cycle o_done, FIFO cleared
module coeff_decompress #(
    parameter int FIFO_DEPTH = 4,
    parameter int SKID       = 2,
    parameter int Q          = 3329
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [63:0] i_words,
    input  logic        i_words_valid,
    input  logic        i_done,
    input  logic [3:0]  i_l,
    output logic        o_in_ready,
    output logic [11:0] o_coeff,
    output logic        o_coeff_valid,
    input  logic        i_coeff_ready,
    output logic [7:0]  o_coeff_idx,
    output logic        o_last,
    output logic        o_done,
    output logic        o_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [22:0] QW = 23'(Q);
    localparam logic [11:0] QC = 12'(Q);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t        state;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [AW:0]   free_cnt;
    logic [3:0]    l_q;
    logic [5:0]    k;
    logic [5:0]    k_max;
    logic [8:0]    load_cnt;
    logic [8:0]    xfer_cnt;
    logic          done_seen;

    logic          fifo_empty;
    logic          fifo_full;
    logic          xfer;
    logic          load_en;
    logic          avail;
    logic          do_load;
    logic          k_last;
    logic          pop;
    logic          wr_req;
    logic          wr_en;
    logic          overflow;
    logic          drop_done;
    logic          done_any;

    logic [63:0]   head;
    logic [6:0]    field_end;
    logic [6:0]    shift;
    logic [11:0]   mask;
    logic [11:0]   y;
    logic [22:0]   prod;
    logic [23:0]   rounded;
    logic [11:0]   coeff_next;

    function automatic logic [3:0] legal_l(input logic [3:0] l);
        case (l)
            4'd1, 4'd4, 4'd5, 4'd10, 4'd11, 4'd12: return l;
            default:                              return 4'd12;
        endcase
    endfunction

    // Index of the last field in a word (fields per word minus one).
    function automatic logic [5:0] last_field(input logic [3:0] l);
        case (l)
            4'd1:    return 6'd63;
            4'd4:    return 6'd15;
            4'd5:    return 6'd11;
            4'd10:   return 6'd5;
            default: return 6'd4;
        endcase
    endfunction

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
    assign free_cnt   = (AW+1)'(FIFO_DEPTH) - count;
    assign o_in_ready = (free_cnt >= (AW+1)'(SKID));

    assign xfer      = o_coeff_valid & i_coeff_ready;
    assign load_en   = ~o_coeff_valid | i_coeff_ready;
    assign avail     = (state == S_RUN) & ~fifo_empty & ~load_cnt[8];
    assign do_load   = load_en & avail;
    assign k_max     = last_field(l_q);
    assign k_last    = (k == k_max);
    assign pop       = (do_load & k_last) | ((state == S_FLUSH) & ~fifo_empty);
    assign wr_req    = i_words_valid & ((state == S_IDLE) | (state == S_RUN));
    assign wr_en     = wr_req & (~fifo_full | pop);
    assign overflow  = wr_req & fifo_full & ~pop;
    assign drop_done = i_words_valid & (state == S_DONE);
    assign done_any  = done_seen | i_done;

    assign head = mem[rd_ptr];

    always_comb begin
        field_end = 7'((7'(k) + 7'd1) * 7'(l_q));
        shift     = 7'd64 - field_end;
        mask      = 12'((13'd1 << l_q) - 13'd1);
        y         = 12'(head >> shift) & mask;
        prod      = 23'(y) * QW;
        rounded   = {1'b0, prod} + (24'd1 << (l_q - 4'd1));
        if (l_q == 4'd12) begin
            coeff_next = (y >= QC) ? (y - QC) : y;
        end else begin
            coeff_next = 12'(rounded >> l_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= i_words;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (state == S_DONE) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= S_IDLE;
            l_q           <= 4'd12;
            k             <= '0;
            load_cnt      <= '0;
            xfer_cnt      <= '0;
            done_seen     <= 1'b0;
            o_coeff       <= '0;
            o_coeff_valid <= 1'b0;
            o_coeff_idx   <= '0;
            o_last        <= 1'b0;
            o_done        <= 1'b0;
            o_err         <= 1'b0;
        end else begin
            o_done <= 1'b0;
            if (xfer) xfer_cnt <= xfer_cnt + 9'd1;
            if (overflow || drop_done) o_err <= 1'b1;

            if (load_en) begin
                o_coeff_valid <= avail;
                if (avail) begin
                    o_coeff     <= coeff_next;
                    o_coeff_idx <= load_cnt[7:0];
                    o_last      <= (load_cnt == 9'd255);
                    load_cnt    <= load_cnt + 9'd1;
                    k           <= k_last ? 6'd0 : k + 6'd1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (i_words_valid) begin
                        state     <= S_RUN;
                        l_q       <= legal_l(i_l);
                        o_err     <= 1'b0;
                        xfer_cnt  <= '0;
                        load_cnt  <= '0;
                        k         <= '0;
                        done_seen <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (i_done) done_seen <= 1'b1;
                    if (xfer && o_last) begin
                        state <= S_FLUSH;
                        k     <= '0;
                    // Short input: producer finished and nothing left anywhere in the pipe.
                    end else if (done_any && fifo_empty && !wr_en && !o_coeff_valid
                                 && !xfer_cnt[8]) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                        o_err  <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (i_done) done_seen <= 1'b1;
                    if (done_any) begin
                        state  <= S_DONE;
                        o_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    state         <= S_IDLE;
                    done_seen     <= 1'b0;
                    k             <= '0;
                    o_coeff_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_decompress.sv
// Randomized bench for coeff_decompress against a queue-based reference of
// the Kyber unpack/decompress rules.
module tb_coeff_decompress;

    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic [63:0] i_words = '0;
    logic        i_words_valid = 1'b0;
    logic        i_done = 1'b0;
    logic [3:0]  i_l = 4'd12;
    logic        o_in_ready;
    logic [11:0] o_coeff;
    logic        o_coeff_valid;
    logic        i_coeff_ready = 1'b1;
    logic [7:0]  o_coeff_idx;
    logic        o_last;
    logic        o_done;
    logic        o_err;

    coeff_decompress dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .i_words       (i_words),
        .i_words_valid (i_words_valid),
        .i_done        (i_done),
        .i_l           (i_l),
        .o_in_ready    (o_in_ready),
        .o_coeff       (o_coeff),
        .o_coeff_valid (o_coeff_valid),
        .i_coeff_ready (i_coeff_ready),
        .o_coeff_idx   (o_coeff_idx),
        .o_last        (o_last),
        .o_done        (o_done),
        .o_err         (o_err)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;

    logic [63:0] wq [$];
    int          exp_q [$];
    logic [11:0] got_c [$];
    logic [7:0]  got_i [$];
    logic        got_l [$];

    int          done_cnt = 0;
    int          stall_viol = 0;
    int          rdy_low_cnt = 0;
    bit          stalled_prev = 1'b0;
    logic [11:0] prev_c = '0;
    logic [7:0]  prev_i = '0;
    bit          abort = 1'b0;
    int          last_base = 0;
    int          last_sb = 0;
    int          last_rb = 0;

    // Observe away from the rising edge.
    always @(negedge i_clk) begin
        if (o_coeff_valid && i_coeff_ready) begin
            got_c.push_back(o_coeff);
            got_i.push_back(o_coeff_idx);
            got_l.push_back(o_last);
        end
        if (o_done) done_cnt++;
        if (!o_in_ready) rdy_low_cnt++;
        if (stalled_prev && o_coeff_valid && (o_coeff !== prev_c || o_coeff_idx !== prev_i))
            stall_viol++;
        stalled_prev = o_coeff_valid && !i_coeff_ready;
        prev_c = o_coeff;
        prev_i = o_coeff_idx;
    end

    // Reference: split each word into 64/l fields from the MSB end, round y*Q/2^l.
    function automatic void build_exp(input int l);
        int n;
        n = 64 / l;
        exp_q.delete();
        foreach (wq[w]) begin
            for (int f = 0; f < n; f++) begin
                if (exp_q.size() < 256) begin
                    logic [63:0] t;
                    int y;
                    t = wq[w] >> (64 - (f + 1) * l);
                    y = int'(t & ((64'd1 << l) - 64'd1));
                    if (l == 12) exp_q.push_back((y >= 3329) ? y - 3329 : y);
                    else         exp_q.push_back((2 * y * 3329 + (1 << l)) / (1 << (l + 1)));
                end
            end
        end
    endfunction

    task automatic drive_words(input int nw, input bit honor, input bit send_done);
        int i;
        int cyc;
        i = 0;
        cyc = 0;
        while (i < nw && !abort && cyc < 8000) begin
            @(posedge i_clk); #1;
            cyc++;
            if (abort) break;
            if (!honor || o_in_ready) begin
                i_words = wq[i];
                i_words_valid = 1'b1;
                i++;
            end else begin
                i_words_valid = 1'b0;
            end
        end
        @(posedge i_clk); #1;
        i_words_valid = 1'b0;
        if (send_done && !abort) begin
            i_done = 1'b1;
            @(posedge i_clk); #1;
            i_done = 1'b0;
        end
    endtask

    // Streams wq as one polynomial and checks the output stream against the reference.
    task automatic run_poly(input int l, input int rmode, input string name);
        int db;
        int n;
        int nexp;
        bit exp_err;
        build_exp(l);
        last_base = got_c.size();
        last_sb = stall_viol;
        last_rb = rdy_low_cnt;
        db = done_cnt;
        i_l = 4'(l);
        i_coeff_ready = 1'b1;
        fork
            drive_words(wq.size(), 1'b1, 1'b1);
            begin
                int cyc;
                cyc = 0;
                while (done_cnt == db && cyc < 10000) begin
                    @(posedge i_clk); #1;
                    cyc++;
                    case (rmode)
                        0:       i_coeff_ready = 1'b1;
                        1:       i_coeff_ready = ~i_coeff_ready;
                        default: i_coeff_ready = 1'($urandom_range(0, 1));
                    endcase
                end
            end
        join
        repeat (2) @(posedge i_clk);
        #1;
        i_coeff_ready = 1'b1;

        total++;
        if (done_cnt - db !== 1) begin
            bad++;
            $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - db);
        end
        n = got_c.size() - last_base;
        nexp = exp_q.size();
        total++;
        if (n !== nexp) begin
            bad++;
            $display("FAIL %s coeff_count: got %0d want %0d", name, n, nexp);
        end
        for (int i = 0; i < n && i < nexp; i++) begin
            total++;
            if (got_c[last_base+i] !== 12'(exp_q[i])) begin
                bad++;
                $display("FAIL %s coeff[%0d]: got %0d want %0d", name, i, got_c[last_base+i], exp_q[i]);
                break;
            end
            total++;
            if (got_i[last_base+i] !== 8'(i)) begin
                bad++;
                $display("FAIL %s idx[%0d]: got %0d want %0d", name, i, got_i[last_base+i], i);
                break;
            end
            total++;
            if (got_l[last_base+i] !== (i == 255)) begin
                bad++;
                $display("FAIL %s last[%0d]: got %0b want %0b", name, i, got_l[last_base+i], (i == 255));
                break;
            end
        end
        exp_err = (nexp < 256);
        total++;
        if (o_err !== exp_err) begin
            bad++;
            $display("FAIL %s err: got %0b want %0b", name, o_err, exp_err);
        end
    endtask

    task automatic do_reset();
        i_words_valid = 1'b0;
        i_done = 1'b0;
        @(posedge i_clk); #1;
        i_rstn = 1'b0;
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
    endtask

    task automatic test_reset();
        i_rstn = 1'b0;
        #1;
        total++;
        if (o_in_ready !== 1'b1) begin bad++; $display("FAIL reset in_ready: got %0b want 1", o_in_ready); end
        total++;
        if ({o_coeff_valid, o_coeff, o_coeff_idx, o_last, o_done, o_err} !== 24'd0) begin
            bad++;
            $display("FAIL reset outputs: got v=%0b c=%0d i=%0d l=%0b d=%0b e=%0b want all 0",
                     o_coeff_valid, o_coeff, o_coeff_idx, o_last, o_done, o_err);
        end
        repeat (2) @(posedge i_clk);
        #1;
        i_rstn = 1'b1;
    endtask

    task automatic test_l1();
        wq.delete();
        repeat (4) wq.push_back(64'hFFFF_FFFF_FFFF_FFFF);
        run_poly(1, 0, "l1");
        total++;
        if (got_c[last_base+255] !== 12'd1665) begin
            bad++;
            $display("FAIL l1 coeff255: got %0d want 1665", got_c[last_base+255]);
        end
    endtask

    task automatic test_l4();
        wq.delete();
        repeat (16) wq.push_back(64'h0123_4567_89AB_CDEF);
        run_poly(4, 2, "l4");
        total++;
        if (got_c[last_base+1] !== 12'd208) begin
            bad++;
            $display("FAIL l4 nibble1: got %0d want 208", got_c[last_base+1]);
        end
        total++;
        if (got_c[last_base+15] !== 12'd3121) begin
            bad++;
            $display("FAIL l4 nibble15: got %0d want 3121", got_c[last_base+15]);
        end
    endtask

    task automatic test_l12_short();
        logic [11:0] want [5];
        want = '{12'd0, 12'd766, 12'd0, 12'd2048, 12'd3328};
        wq.delete();
        wq.push_back(64'hD01F_FF00_0800_D000);
        run_poly(12, 0, "l12");
        for (int i = 0; i < 5; i++) begin
            total++;
            if (got_c[last_base+i] !== want[i]) begin
                bad++;
                $display("FAIL l12 field%0d: got %0d want %0d", i, got_c[last_base+i], want[i]);
            end
        end
    endtask

    // Follows the short l12 polynomial without reset: o_err must be cleared on restart.
    task automatic test_back_to_back();
        wq.delete();
        repeat (22) wq.push_back({$urandom, $urandom});
        run_poly(5, 2, "l5_b2b");
    endtask

    task automatic test_l10_stall();
        wq.delete();
        repeat (43) wq.push_back({$urandom, $urandom});
        run_poly(10, 1, "l10_stall");
        total++;
        if (stall_viol - last_sb !== 0) begin
            bad++;
            $display("FAIL stall_hold: got %0d changes while stalled want 0", stall_viol - last_sb);
        end
        total++;
        if (rdy_low_cnt - last_rb == 0) begin
            bad++;
            $display("FAIL in_ready_throttle: got 0 low cycles want >0");
        end
    endtask

    task automatic test_overflow();
        do_reset();
        i_l = 4'd10;
        i_coeff_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge i_clk); #1;
            i_words = {$urandom, $urandom};
            i_words_valid = 1'b1;
        end
        @(posedge i_clk); #1;
        i_words_valid = 1'b0;
        total++;
        if (o_err !== 1'b0) begin bad++; $display("FAIL ovf_full_no_err: got %0b want 0", o_err); end
        total++;
        if (o_in_ready !== 1'b0) begin bad++; $display("FAIL ovf_in_ready: got %0b want 0", o_in_ready); end
        i_words_valid = 1'b1;
        @(posedge i_clk); #1;
        i_words_valid = 1'b0;
        total++;
        if (o_err !== 1'b1) begin bad++; $display("FAIL ovf_err: got %0b want 1", o_err); end
        i_coeff_ready = 1'b1;
        do_reset();
    endtask

    task automatic test_reset_mid();
        int base;
        wq.delete();
        repeat (16) wq.push_back({$urandom, $urandom});
        i_l = 4'd4;
        i_coeff_ready = 1'b1;
        base = got_c.size();
        fork
            drive_words(16, 1'b1, 1'b1);
            begin
                int cyc;
                cyc = 0;
                while (got_c.size() - base < 100 && cyc < 5000) begin
                    @(posedge i_clk); #1;
                    cyc++;
                end
                i_rstn = 1'b0;
                abort = 1'b1;
            end
        join
        i_words_valid = 1'b0;
        i_done = 1'b0;
        #1;
        total++;
        if (got_c.size() - base < 100) begin
            bad++;
            $display("FAIL rst_mid_progress: got %0d coeffs want >=100", got_c.size() - base);
        end
        total++;
        if ({o_coeff_valid, o_coeff, o_coeff_idx, o_last, o_done, o_err} !== 24'd0 || o_in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_outputs: got v=%0b c=%0d i=%0d rdy=%0b want 0/0/0/1",
                     o_coeff_valid, o_coeff, o_coeff_idx, o_in_ready);
        end
        @(posedge i_clk); #1;
        i_rstn = 1'b1;
        abort = 1'b0;
        wq.delete();
        wq.push_back({11'h7FF, 21'($urandom), $urandom});
        repeat (51) wq.push_back({$urandom, $urandom});
        run_poly(11, 2, "l11_restart");
        total++;
        if (got_c[last_base] !== 12'd3327) begin
            bad++;
            $display("FAIL l11_2047: got %0d want 3327", got_c[last_base]);
        end
    endtask

    initial begin
        test_reset();
        test_l1();
        test_l4();
        test_l12_short();
        test_back_to_back();
        test_l10_stall();
        test_overflow();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
